ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter that sends single command bytes to the keyboard, such as 0xED LED-set followed by an LED mask for the RUS/LAT indicator, 0xFF reset, and 0xF4 enable.
- Sits beside the PS/2 receiver and the keycode translator.
- Shares the open-drain ps2 clock and data lines with the receiver.
- Performs the inhibit, request-to-send, bit shifting, acknowledge check and timeout sequence, then reports completion or error.

Parameters:
- CLK_KHZ, 48000, clk_sys frequency in kHz.
- INHIBIT_US, 120, time ps2 clock is held low before request-to-send, in µs.
- TIMEOUT_US, 15000, maximum allowed gap between device clock falling edges, in µs.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk_i  in  1  ps2 clock line level (asynchronous).
- ps2_dat_i  in  1  ps2 data line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull ps2 clock low.
- ps2_dat_oe  out  1  1 = pull ps2 data low.
- tx_data  in  8  byte to send.
- tx_strobe  in  1  one-cycle request; tx_data is sampled in the same cycle.
- busy  out  1  high from the accepted strobe until done or error.
- done  out  1  one-cycle pulse: byte sent and acknowledged.
- error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Input conditioning
  - ps2_clk_i and ps2_dat_i each pass through a 2-FF synchroniser.
  - fall = previous synced clock 1 and current synced clock 0.
- Reset (asynchronous)
  - All outputs 0 and state IDLE, so both lines are released immediately, including mid-frame.
- Derived constants
  - INH_CYC = CLK_KHZ*INHIBIT_US/1000.
  - TO_CYC = CLK_KHZ*TIMEOUT_US/1000.
  - The counter is wide enough for TO_CYC.
- Frame latch
  - On accept, shreg ← tx_data and par ← ~^tx_data (odd parity).
- IDLE
  - Both oe are 0 and busy is 0.
  - tx_strobe=1: latch the frame, set busy=1 on the next cycle, go to INHIBIT and clear the counter.
- INHIBIT
  - ps2_clk_oe=1 and ps2_dat_oe=0.
  - When the counter reaches INH_CYC-1: ps2_dat_oe=1 (start bit), go to RTS.
- RTS
  - ps2_dat_oe=1 and ps2_clk_oe=0 (clock released one cycle after data is pulled low).
  - On fall: drive bit0, set bitcnt=0, go to DATA.
- DATA
  - ps2_dat_oe = ~current bit.
  - On fall: shift right and increment bitcnt.
  - After bit7 has been presented and a fall occurs: present par, go to PARITY.
- PARITY
  - ps2_dat_oe = ~par.
  - On fall: ps2_dat_oe=0 (stop bit = released line), go to STOP.
- STOP
  - On fall: go to ACK.
- ACK
  - On fall: sample synced data.
  - Data 0: go to WAIT_REL.
  - Data 1: error pulse, go to IDLE.
- WAIT_REL
  - Wait until synced clock=1 and data=1, then done pulse, go to IDLE.
- Busy and pulses
  - busy=1 in every state except IDLE.
  - busy drops in the same cycle as the done or error pulse.
- Timeout
  - The counter clears on entry to RTS and on every fall in RTS through WAIT_REL.
  - If the counter reaches TO_CYC-1 before the next fall: release both lines, error pulse, go to IDLE.
- Strobe handling
  - tx_strobe while busy=1 is ignored; there is no queue, and the latched byte is unchanged.
- Frame order on the wire
  - start(0), d0..d7 LSB first, odd parity, stop(1), device ACK(0).
- Lines
  - Outputs never actively drive high; they are open-drain enables only.
- Flag exclusivity
  - done and error are never asserted in the same cycle.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz and ACKing.
  - Clock is held low for INH_CYC cycles, then data goes low with the start bit.
  - Bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1.
  - ACK leads to a done pulse and busy low.
- Send 0x02.
  - Data bits 0,1,0,0,0,0,0,0 then parity 0.
  - done pulse follows.
- NACK: device leaves data high on the 11th fall.
  - error pulse, no done.
  - Both oe are 0 the next cycle.
- Timeout: device stops clocking after bit 3.
  - After TO_CYC cycles: error pulse and lines released.
  - A following tx_strobe of 0xF4 completes normally.
- tx_strobe with 0x55 while sending 0xED.
  - Ignored; wire frame stays 0xED.
  - Exactly one done.
- reset_n low during DATA.
  - ps2_clk_oe=0, ps2_dat_oe=0 and busy=0 asynchronously.
  - No done or error pulse.
  - After release, a new 0xFF transmit succeeds.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Runs the inhibit / request-to-send / shift / ACK / release sequence on the
// shared open-drain PS/2 lines and reports done or error.
// Ports:
//   clk_sys, reset_n       system clock, async active-low reset
//   ps2_clk_i, ps2_dat_i   asynchronous line levels
//   ps2_clk_oe, ps2_dat_oe open-drain pull-low enables (1 = pull low)
//   tx_data, tx_strobe     byte to send, one-cycle request
//   busy, done, error      status level and one-cycle result pulses
module ps2_host_tx #(
  parameter int unsigned CLK_KHZ    = 48000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CYC = CLK_KHZ * INHIBIT_US / 1000;
  localparam int unsigned TO_CYC  = CLK_KHZ * TIMEOUT_US / 1000;
  localparam int unsigned CNT_W   = $clog2(TO_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_RTS      = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_PARITY   = 3'd4;
  localparam logic [2:0] S_STOP     = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;
  localparam logic [2:0] S_WAIT_REL = 3'd7;

  logic             r_clk_meta, r_clk_sync, r_clk_prev;
  logic             r_dat_meta, r_dat_sync;
  logic [2:0]       r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [7:0]       r_shreg,  w_shreg_nxt;
  logic             r_par,    w_par_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_dat_oe, w_dat_oe_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_error,  w_error_nxt;
  logic             w_fall, w_active, w_timeout;

  // Two-FF synchronisers; reset to the idle (released, high) line level so no
  // spurious falling edge is seen after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_i;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_i;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_active  = (r_state != S_IDLE) && (r_state != S_INHIBIT);
  assign w_timeout = (r_cnt == CNT_W'(TO_CYC - 1));

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shreg  <= w_shreg_nxt;
      r_par    <= w_par_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_shreg_nxt  = r_shreg;
    w_par_nxt    = r_par;
    w_bitcnt_nxt = r_bitcnt;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt    = r_cnt;
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        if (tx_strobe) begin
          w_shreg_nxt  = tx_data;
          w_par_nxt    = ~^tx_data;
          w_busy_nxt   = 1'b1;
          w_clk_oe_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        if (r_cnt == CNT_W'(INH_CYC - 1)) begin
          // Start bit; the clock stays pulled for one more cycle.
          w_dat_oe_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RTS;
        end
      end
      S_RTS: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b1;
        if (w_fall) begin
          w_dat_oe_nxt = ~r_shreg[0];
          w_bitcnt_nxt = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_cnt_nxt = '0;
          if (r_bitcnt == 3'd7) begin
            w_dat_oe_nxt = ~r_par;
            w_state_nxt  = S_PARITY;
          end else begin
            // Present the next bit, which becomes shreg[0] after the shift.
            w_shreg_nxt  = r_shreg >> 1;
            w_dat_oe_nxt = ~r_shreg[1];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_dat_oe_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_cnt_nxt = '0;
          if (!r_dat_sync) begin
            w_state_nxt = S_WAIT_REL;
          end else begin
            w_error_nxt  = 1'b1;
            w_busy_nxt   = 1'b0;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: begin // S_WAIT_REL
        if (w_fall) w_cnt_nxt = '0;
        if (r_clk_sync && r_dat_sync) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
    endcase

    // Device went silent: abandon the frame and release both lines.
    if (w_active && !w_fall && w_timeout && !w_done_nxt) begin
      w_error_nxt  = 1'b1;
      w_busy_nxt   = 1'b0;
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
      w_state_nxt  = S_IDLE;
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + randomized bench for ps2_host_tx with a PS/2
// device model sharing the open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned CLK_KHZ    = 1000;
  localparam int unsigned INHIBIT_US = 120;
  localparam int unsigned TIMEOUT_US = 2000;
  localparam int INH_CYC = 120;   // 1000 kHz * 120 us
  localparam int TO_CYC  = 2000;  // 1000 kHz * 2000 us
  localparam int HALF    = 42;    // ~12 kHz device clock at 1 MHz

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;
  logic       clk_line, dat_line;

  // Wired-AND open-drain lines with pull-ups.
  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_KHZ(CLK_KHZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk_i (clk_line),
    .ps2_dat_i (dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_data   (tx_data),
    .tx_strobe (tx_strobe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  bit both_flags = 1'b0;
  bit flag_busy = 1'b0;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (done === 1'b1) n_done++;
    if (error === 1'b1) n_err++;
    if (done === 1'b1 && error === 1'b1) both_flags = 1'b1;
    if ((done === 1'b1 || error === 1'b1) && busy !== 1'b0) flag_busy = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {stop, odd parity, data LSB first, start}; bit 0 is the start bit.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    tx_data   = b;
    tx_strobe = 1'b1;
    step(1);
    tx_strobe = 1'b0;
    tx_data   = 8'($urandom);
  endtask

  // Device: wait for request-to-send, then clock nfalls falling edges, reading
  // data on each rising edge, and drive ACK low across falls 11-12 when ack=1.
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits,
                           output int inh, output int gap, output bit ok,
                           output int last_fall);
    int k;
    ok = 1'b1; inh = 0; gap = 0; last_fall = 0; bits = '1;
    k = 0;
    while (dat_line !== 1'b0 && k < 1000) begin
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh++;
      step(1);
      k++;
    end
    if (k >= 1000) ok = 1'b0;
    k = 0;
    while (clk_line !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    gap = k;
    if (k >= 20) ok = 1'b0;
    if (ok) begin
      bits[0] = dat_line;
      step(50);
      for (int f = 1; f <= nfalls; f++) begin
        dev_clk_low = 1'b1;
        last_fall = cyc;
        step(HALF);
        dev_clk_low = 1'b0;
        if (f <= 10) bits[f] = dat_line;
        if (f == 10 && ack) dev_dat_low = 1'b1;
        if (f == 12) dev_dat_low = 1'b0;
        step(HALF);
      end
    end
    dev_dat_low = 1'b0;
  endtask

  logic [10:0] bits;
  int inh, gap, lf, d0, e0, k, lat;
  bit ok;
  logic [7:0] b;

  task automatic run_tx(input logic [7:0] tb_byte, input bit ack, input bit chk_inh);
    logic [10:0] fb;
    int fi, fg, fl, dd, ee;
    bit fok;
    dd = n_done; ee = n_err;
    send(tb_byte);
    check("busy_after_strobe", 32'(busy), 32'd1);
    dev_frame(12, ack, fb, fi, fg, fok, fl);
    check("device_handshake", 32'(fok), 32'd1);
    if (chk_inh) begin
      check("inhibit_cycles", 32'(fi), 32'(INH_CYC));
      check("clk_release_gap", 32'(fg), 32'd1);
    end
    check("wire_frame", 32'(fb), 32'(ref_frame(tb_byte)));
    step(2);
    check("done_count", 32'(n_done - dd), ack ? 32'd1 : 32'd0);
    check("error_count", 32'(n_err - ee), ack ? 32'd0 : 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("clk_oe_end", 32'(ps2_clk_oe), 32'd0);
    check("dat_oe_end", 32'(ps2_dat_oe), 32'd0);
  endtask

  initial begin
    // Reset state.
    step(3);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    step(3);

    // 0xED with inhibit timing, then 0x02.
    run_tx(8'hED, 1'b1, 1'b1);
    run_tx(8'h02, 1'b1, 1'b0);

    // NACK.
    run_tx(8'($urandom), 1'b0, 1'b0);

    // Timeout after bit 3 is presented.
    b = 8'($urandom);
    d0 = n_done; e0 = n_err;
    send(b);
    dev_frame(4, 1'b0, bits, inh, gap, ok, lf);
    check("to_handshake", 32'(ok), 32'd1);
    check("to_partial_bits", 32'(bits[4:1]), 32'(b[3:0]));
    k = 0;
    while (error !== 1'b1 && k < 3 * TO_CYC) begin
      step(1);
      k++;
    end
    check("to_error_seen", 32'(error), 32'd1);
    lat = cyc - lf;
    check("to_latency_window", 32'(lat >= TO_CYC && lat <= TO_CYC + 6), 32'd1);
    check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("to_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    step(2);
    check("to_no_done", 32'(n_done - d0), 32'd0);
    run_tx(8'hF4, 1'b1, 1'b0);

    // Strobe while busy is ignored.
    d0 = n_done; e0 = n_err;
    send(8'hED);
    step(10);
    send(8'h55);
    dev_frame(12, 1'b1, bits, inh, gap, ok, lf);
    check("ign_handshake", 32'(ok), 32'd1);
    check("ign_wire_frame", 32'(bits), 32'(ref_frame(8'hED)));
    step(300);
    check("ign_done_count", 32'(n_done - d0), 32'd1);
    check("ign_error_count", 32'(n_err - e0), 32'd0);
    check("ign_busy", 32'(busy), 32'd0);

    // Asynchronous reset during DATA.
    d0 = n_done; e0 = n_err;
    send(8'hFF);
    dev_frame(5, 1'b0, bits, inh, gap, ok, lf);
    check("rd_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rd_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rd_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rd_busy", 32'(busy), 32'd0);
    step(3);
    reset_n = 1'b1;
    step(3);
    check("rd_no_done", 32'(n_done - d0), 32'd0);
    check("rd_no_error", 32'(n_err - e0), 32'd0);
    run_tx(8'hFF, 1'b1, 1'b0);

    // Random bytes.
    for (int i = 0; i < 4; i++) run_tx(8'($urandom_range(0, 255)), 1'b1, 1'b0);

    check("flags_exclusive", 32'(both_flags), 32'd0);
    check("busy_low_on_pulse", 32'(flag_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
